// File: rtl/vga_scanout_engine_if.sv
// Pixel-buffer read bus: the scan-out engine drives the address, the RAM read port returns data.
interface vga_scanout_engine_if #(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 4
);
  logic [ADDR_W-1:0] PB_ADDR;
  logic [PIX_W-1:0]  PB_DATA;

  modport master (output PB_ADDR, input PB_DATA);
  modport slave  (input PB_ADDR, output PB_DATA);
endinterface

// File: rtl/vga_scanout_engine.sv
// Parametrised VGA timing generator with replicated low-res pixel-buffer scan-out.
// Define VGA_PALETTE_EN to add a 16-entry 12-bit palette lookup stage.
module vga_scanout_engine #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HS_POL      = 0,
  parameter int VS_POL      = 0,
  parameter int SCALE_SHIFT = 2,
  parameter int PIX_W       = 4,
  parameter int ADDR_W      = 15,
  parameter int RD_LAT      = 1
) (
  input  logic                 VGA_CLK,
  input  logic                 VGA_RST_N,
  vga_scanout_engine_if.master pb,
`ifdef VGA_PALETTE_EN
  input  logic                 PAL_WE,
  input  logic [3:0]           PAL_IDX,
  input  logic [11:0]          PAL_DATA,
`endif
  output logic [3:0]           VGA_R,
  output logic [3:0]           VGA_G,
  output logic [3:0]           VGA_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 FRAME_START
);
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL + 1);
  localparam int VW        = $clog2(V_TOTAL + 1);
  localparam int BUF_W     = H_ACTIVE >> SCALE_SHIFT;
  localparam int LAST_ADDR = BUF_W * (V_ACTIVE >> SCALE_SHIFT) - 1;
`ifdef VGA_PALETTE_EN
  localparam int D = RD_LAT + 2;
`else
  localparam int D = RD_LAT + 1;
`endif

  localparam logic [HW-1:0]     H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     HS_START   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0]     VS_START   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]     SCALE_MASK = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] BUF_W_A    = ADDR_W'(BUF_W);
  localparam logic              HS_ACT     = 1'(HS_POL);
  localparam logic              VS_ACT     = 1'(VS_POL);

  if (LAST_ADDR > (2 ** ADDR_W) - 1) begin : g_addr_range
    $error("vga_scanout_engine: pixel buffer does not fit in ADDR_W address bits");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_lat_range
    $error("vga_scanout_engine: RD_LAT must be 1..3");
  end

  typedef struct packed {
    logic fs;
    logic vs;
    logic hs;
    logic act;
  } pos_t;

  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic              line_end;
  pos_t              pos_c;
  pos_t              pipe_q [D];
  logic [11:0]       rgb_q;

  always_comb begin
    line_end   = (h_cnt_q == H_LAST);
    h_cnt_d    = line_end ? '0 : h_cnt_q + 1'b1;
    v_cnt_d    = v_cnt_q;
    row_base_d = row_base_q;
    if (line_end) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      // Clearing after the last visible line keeps the idle address inside the buffer.
      if (v_cnt_q == V_ACT_LAST) begin
        row_base_d = '0;
      end else if (v_cnt_q < V_ACT_END && (v_cnt_q & SCALE_MASK) == SCALE_MASK) begin
        row_base_d = row_base_q + BUF_W_A;
      end
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RST_N) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      row_base_q <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      row_base_q <= row_base_d;
    end
  end

  always_comb begin
    pos_c.act = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
    pos_c.hs  = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
    pos_c.vs  = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
    pos_c.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  assign pb.PB_ADDR = pos_c.act ? row_base_q + ADDR_W'(h_cnt_q >> SCALE_SHIFT) : row_base_q;

  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RST_N) begin
      for (int i = 0; i < D; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pos_c;
      for (int i = 1; i < D; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

`ifdef VGA_PALETTE_EN
  logic [11:0] pal_q [16];
  logic [3:0]  pix_q;
  logic [PIX_W+3:0] pix_ext;

  assign pix_ext = {4'b0000, pb.PB_DATA};

  // Palette read uses the pre-write value, so a same-clock write takes effect next clock.
  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RST_N) begin
      for (int i = 0; i < 16; i++) pal_q[i] <= {3{4'(i)}};
      pix_q <= '0;
      rgb_q <= '0;
    end else begin
      if (PAL_WE) pal_q[PAL_IDX] <= PAL_DATA;
      pix_q <= pix_ext[3:0];
      rgb_q <= pipe_q[RD_LAT].act ? pal_q[pix_q] : 12'h000;
    end
  end
`else
  function automatic logic [3:0] grey(input logic [PIX_W-1:0] p);
    logic [3:0] g;
    g = '0;
    for (int i = 0; i < 4; i++) g[3-i] = p[PIX_W-1-(i % PIX_W)];
    return g;
  endfunction

  always_ff @(posedge VGA_CLK) begin
    if (!VGA_RST_N) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= pipe_q[RD_LAT-1].act ? {3{grey(pb.PB_DATA)}} : 12'h000;
    end
  end
`endif

  assign VGA_R       = rgb_q[11:8];
  assign VGA_G       = rgb_q[7:4];
  assign VGA_B       = rgb_q[3:0];
  assign VGA_HS      = pipe_q[D-1].hs ? HS_ACT : ~HS_ACT;
  assign VGA_VS      = pipe_q[D-1].vs ? VS_ACT : ~VS_ACT;
  assign FRAME_START = pipe_q[D-1].fs;
endmodule
